// File: rtl/npu_out_pkg.sv
// Shared constants and helpers for the NPU output stage.
// Default geometry of the ReLU / quantise / serialise path.
package npu_out_pkg;

    localparam int N_LANES_D = 8;
    localparam int ACC_W_D   = 24;
    localparam int OUT_W_D   = 8;
    localparam int SHIFT_D   = 8;

    function automatic int out_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/npu_relu_sat_lane.sv
// One lane of the output transform: ReLU, arithmetic shift, saturate.
// Purely combinational; instantiated once per MAC lane.
import npu_out_pkg::*;

module npu_relu_sat_lane #(
    parameter int ACC_W = ACC_W_D,
    parameter int OUT_W = OUT_W_D,
    parameter int SHIFT = SHIFT_D
) (
    input  logic [ACC_W-1:0] i_acc,
    output logic [OUT_W-1:0] o_q
);

    localparam logic [ACC_W-1:0] SAT = ACC_W'(out_max(OUT_W));

    logic [ACC_W-1:0] w_shr;

    // negatives are zeroed below, so a logical shift is enough here
    assign w_shr = i_acc >> SHIFT;

    always_comb begin
        o_q = w_shr[OUT_W-1:0];
        if (i_acc[ACC_W-1]) begin
            o_q = '0;
        end else if (w_shr > SAT) begin
            o_q = '1;
        end
    end

endmodule

// File: rtl/npu_relu_piso.sv
// NPU output stage: capture, ReLU-quantise, ping-pong buffer and
// serialise accumulator vectors over a valid/ready stream.
import npu_out_pkg::*;

module npu_relu_piso #(
    parameter int N_LANES = N_LANES_D,
    parameter int ACC_W   = ACC_W_D,
    parameter int OUT_W   = OUT_W_D,
    parameter int SHIFT   = SHIFT_D
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     EN_ReLU,
    input  logic                     CLR_PISO_OUT,
    input  logic [N_LANES*ACC_W-1:0] acc_in,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [OUT_W-1:0]         out_data,
    output logic                     out_last,
    output logic                     OUT_DONE,
    output logic                     err_overflow
);

    localparam int LW = $clog2(N_LANES);
    localparam int VW = N_LANES * OUT_W;
    localparam logic [LW-1:0] LAST = LW'(N_LANES - 1);

    logic [VW-1:0]    w_q;
    logic [VW-1:0]    r_buf [2];
    logic             r_wp;
    logic             r_rp;
    logic [1:0]       r_count;
    logic [LW-1:0]    r_lane;
    logic [OUT_W-1:0] r_data;
    logic             r_last;
    logic             r_err;

    logic [VW-1:0]    w_cur;
    logic [VW-1:0]    w_nxt;
    logic [LW-1:0]    w_lane_nx;
    logic             w_valid;
    logic             w_fire;
    logic             w_last_lane;
    logic             w_pop_last;
    logic             w_cap_req;
    logic             w_full;
    logic             w_cap;

    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        npu_relu_sat_lane #(
            .ACC_W (ACC_W),
            .OUT_W (OUT_W),
            .SHIFT (SHIFT)
        ) u_lane (
            .i_acc (acc_in[g*ACC_W +: ACC_W]),
            .o_q   (w_q[g*OUT_W +: OUT_W])
        );
    end

    assign w_cur       = r_buf[r_rp];
    assign w_nxt       = r_buf[~r_rp];
    assign w_lane_nx   = r_lane + 1'b1;
    assign w_valid     = (r_count != 2'd0);
    assign w_fire      = enable & w_valid & out_ready;
    assign w_last_lane = (r_lane == LAST);
    assign w_pop_last  = w_fire & w_last_lane;
    assign w_cap_req   = enable & EN_ReLU & ~CLR_PISO_OUT;
    // a final-lane pop frees the slot in the same cycle
    assign w_full      = (r_count == 2'd2) & ~w_pop_last;
    assign w_cap       = w_cap_req & ~w_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buf[0] <= '0;
            r_buf[1] <= '0;
            r_wp     <= 1'b0;
            r_rp     <= 1'b0;
            r_count  <= 2'd0;
            r_lane   <= '0;
            r_data   <= '0;
            r_last   <= 1'b0;
            r_err    <= 1'b0;
        end else if (enable) begin
            if (CLR_PISO_OUT) begin
                r_wp    <= 1'b0;
                r_rp    <= 1'b0;
                r_count <= 2'd0;
                r_lane  <= '0;
                r_data  <= '0;
                r_last  <= 1'b0;
                r_err   <= 1'b0;
            end else begin
                if (w_cap) begin
                    r_buf[r_wp] <= w_q;
                    r_wp        <= ~r_wp;
                end
                if (w_cap_req && w_full) begin
                    r_err <= 1'b1;
                end
                case ({w_cap, w_pop_last})
                    2'b10:   r_count <= r_count + 2'd1;
                    2'b01:   r_count <= r_count - 2'd1;
                    default: r_count <= r_count;
                endcase
                if (w_fire) begin
                    if (w_last_lane) begin
                        r_lane <= '0;
                        r_rp   <= ~r_rp;
                        r_last <= 1'b0;
                        // with one entry left, the next vector can only be
                        // the one being captured right now
                        r_data <= (r_count == 2'd1) ? w_q[OUT_W-1:0]
                                                    : w_nxt[OUT_W-1:0];
                    end else begin
                        r_lane <= w_lane_nx;
                        r_data <= w_cur[w_lane_nx*OUT_W +: OUT_W];
                        r_last <= (w_lane_nx == LAST);
                    end
                end else if (w_cap && r_count == 2'd0) begin
                    r_data <= w_q[OUT_W-1:0];
                    r_last <= 1'b0;
                end
            end
        end
    end

    assign out_valid    = w_valid;
    assign out_data     = r_data;
    assign out_last     = r_last;
    assign OUT_DONE     = (r_count == 2'd0);
    assign err_overflow = r_err;

endmodule
